// File: rtl/dco_cap_encoder_if.sv
// Target-word handshake between the loop filter / PVT logic and the DCO capacitor encoder.
interface dco_cap_encoder_if;
  logic [4:0] tune_l;
  logic [8:0] tune_m;
  logic [8:0] tune_s;
  logic       tune_vld;
  logic       tune_rdy;

  modport master (output tune_l, output tune_m, output tune_s, output tune_vld, input tune_rdy);
  modport slave  (input tune_l, input tune_m, input tune_s, input tune_vld, output tune_rdy);
endinterface

// File: rtl/dco_cap_encoder.sv
// Slews the L/M/S capacitor-bank codes toward accepted targets (L, then M, then S) and
// drives the registered r_all/row/col selects decoded by the DCO bank cells.
module dco_cap_encoder #(
  parameter int STEP_L = 1,
  parameter int STEP_M = 4,
  parameter int STEP_S = 16,
  parameter int INIT_L = 12,
  parameter int INIT_M = 128,
  parameter int INIT_S = 128
) (
  input  logic                clk,
  input  logic                rst,
  dco_cap_encoder_if.slave    tune_if,
  output logic                done,
  output logic [4:0]          c_l_r_all,
  output logic [4:0]          c_l_row,
  output logic [4:0]          c_l_col,
  output logic [15:0]         c_m_r_all,
  output logic [15:0]         c_m_row,
  output logic [15:0]         c_m_col,
  output logic [15:0]         c_s_r_all,
  output logic [15:0]         c_s_row,
  output logic [15:0]         c_s_col,
  output logic [4:0]          code_l,
  output logic [8:0]          code_m,
  output logic [8:0]          code_s
);

  // state  | meaning
  // IDLE   | ready for a new target, codes static
  // SLEW_L | stepping L code toward target
  // SLEW_M | stepping M code toward target
  // SLEW_S | stepping S code toward target; exit pulses done
  typedef enum logic [1:0] {IDLE, SLEW_L, SLEW_M, SLEW_S} state_t;

  state_t     state_q, state_d;
  logic [4:0] code_l_q, code_l_d, tgt_l_q;
  logic [8:0] code_m_q, code_m_d, tgt_m_q;
  logic [8:0] code_s_q, code_s_d, tgt_s_q;
  logic       rdy_q, rdy_d;
  logic       done_q, done_d;
  logic       accept;

  logic [4:0]  c_l_r_all_q, c_l_row_q, c_l_col_q;
  logic [15:0] c_m_r_all_q, c_m_row_q, c_m_col_q;
  logic [15:0] c_s_r_all_q, c_s_row_q, c_s_col_q;

  // Moves code toward tgt by at most step; the signed difference keeps downward slews from wrapping.
  function automatic logic [8:0] step_fn(input logic [8:0] code, input logic [8:0] tgt, input int step);
    logic signed [9:0] diff;
    logic signed [9:0] stp;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, code});
    stp  = 10'(step);
    if (diff > stp)       step_fn = code + stp[8:0];
    else if (diff < -stp) step_fn = code - stp[8:0];
    else                  step_fn = tgt;
  endfunction

  function automatic logic [15:0] f_rall(input logic [8:0] n, input int k);
    int q;
    q = int'(n) / k;
    for (int i = 0; i < 16; i++) f_rall[i] = (i < q);
  endfunction

  function automatic logic [15:0] f_row(input logic [8:0] n, input int k);
    int q;
    q = int'(n) / k;
    for (int i = 0; i < 16; i++) f_row[i] = (i == q);
  endfunction

  function automatic logic [15:0] f_col(input logic [8:0] n, input int k);
    int r;
    r = int'(n) % k;
    for (int i = 0; i < 16; i++) f_col[i] = (i < r);
  endfunction

  assign accept = tune_if.tune_vld && rdy_q;

  always_comb begin
    state_d  = state_q;
    code_l_d = code_l_q;
    code_m_d = code_m_q;
    code_s_d = code_s_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SLEW_L;
          rdy_d   = 1'b0;
        end
      end
      SLEW_L: begin
        if (code_l_q == tgt_l_q) state_d = SLEW_M;
        else code_l_d = 5'(step_fn({4'b0, code_l_q}, {4'b0, tgt_l_q}, STEP_L));
      end
      SLEW_M: begin
        if (code_m_q == tgt_m_q) state_d = SLEW_S;
        else code_m_d = step_fn(code_m_q, tgt_m_q, STEP_M);
      end
      SLEW_S: begin
        if (code_s_q == tgt_s_q) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          code_s_d = step_fn(code_s_q, tgt_s_q, STEP_S);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects are encoded from the next codes so they update on the same edge as code_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      code_l_q    <= 5'(INIT_L);
      code_m_q    <= 9'(INIT_M);
      code_s_q    <= 9'(INIT_S);
      tgt_l_q     <= 5'(INIT_L);
      tgt_m_q     <= 9'(INIT_M);
      tgt_s_q     <= 9'(INIT_S);
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      c_l_r_all_q <= 5'(f_rall(9'(INIT_L), 5));
      c_l_row_q   <= 5'(f_row(9'(INIT_L), 5));
      c_l_col_q   <= 5'(f_col(9'(INIT_L), 5));
      c_m_r_all_q <= f_rall(9'(INIT_M), 16);
      c_m_row_q   <= f_row(9'(INIT_M), 16);
      c_m_col_q   <= f_col(9'(INIT_M), 16);
      c_s_r_all_q <= f_rall(9'(INIT_S), 16);
      c_s_row_q   <= f_row(9'(INIT_S), 16);
      c_s_col_q   <= f_col(9'(INIT_S), 16);
    end else begin
      state_q  <= state_d;
      code_l_q <= code_l_d;
      code_m_q <= code_m_d;
      code_s_q <= code_s_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      if (state_q == IDLE && accept) begin
        tgt_l_q <= (tune_if.tune_l > 5'd25)  ? 5'd25  : tune_if.tune_l;
        tgt_m_q <= (tune_if.tune_m > 9'd256) ? 9'd256 : tune_if.tune_m;
        tgt_s_q <= (tune_if.tune_s > 9'd256) ? 9'd256 : tune_if.tune_s;
      end
      c_l_r_all_q <= 5'(f_rall({4'b0, code_l_d}, 5));
      c_l_row_q   <= 5'(f_row({4'b0, code_l_d}, 5));
      c_l_col_q   <= 5'(f_col({4'b0, code_l_d}, 5));
      c_m_r_all_q <= f_rall(code_m_d, 16);
      c_m_row_q   <= f_row(code_m_d, 16);
      c_m_col_q   <= f_col(code_m_d, 16);
      c_s_r_all_q <= f_rall(code_s_d, 16);
      c_s_row_q   <= f_row(code_s_d, 16);
      c_s_col_q   <= f_col(code_s_d, 16);
    end
  end

  assign tune_if.tune_rdy = rdy_q;
  assign done      = done_q;
  assign code_l    = code_l_q;
  assign code_m    = code_m_q;
  assign code_s    = code_s_q;
  assign c_l_r_all = c_l_r_all_q;
  assign c_l_row   = c_l_row_q;
  assign c_l_col   = c_l_col_q;
  assign c_m_r_all = c_m_r_all_q;
  assign c_m_row   = c_m_row_q;
  assign c_m_col   = c_m_col_q;
  assign c_s_r_all = c_s_r_all_q;
  assign c_s_row   = c_s_row_q;
  assign c_s_col   = c_s_col_q;

endmodule

// File: tb/tb_dco_cap_encoder.sv
// Directed bench for dco_cap_encoder: reset encoding, slew timing, clamping, underflow, abort.
module tb_dco_cap_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done;
  logic [4:0]  c_l_r_all, c_l_row, c_l_col;
  logic [15:0] c_m_r_all, c_m_row, c_m_col;
  logic [15:0] c_s_r_all, c_s_row, c_s_col;
  logic [4:0]  code_l;
  logic [8:0]  code_m, code_s;
  int total = 0;
  int bad = 0;
  int n;

  dco_cap_encoder_if tif ();

  dco_cap_encoder dut (
    .clk(clk), .rst(rst), .tune_if(tif.slave), .done(done),
    .c_l_r_all(c_l_r_all), .c_l_row(c_l_row), .c_l_col(c_l_col),
    .c_m_r_all(c_m_r_all), .c_m_row(c_m_row), .c_m_col(c_m_col),
    .c_s_r_all(c_s_r_all), .c_s_row(c_s_row), .c_s_col(c_s_col),
    .code_l(code_l), .code_m(code_m), .code_s(code_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [4:0] l, input logic [8:0] m, input logic [8:0] s);
    @(negedge clk);
    tif.tune_l = l; tif.tune_m = m; tif.tune_s = s; tif.tune_vld = 1'b1;
    @(posedge clk); #1;
    tif.tune_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
  endtask

  initial begin
    tif.tune_l = '0; tif.tune_m = '0; tif.tune_s = '0; tif.tune_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code_l", 32'(code_l), 32'd12);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("init_code_m", 32'(code_m), 32'd128);
    chk("init_code_s", 32'(code_s), 32'd128);
    chk("init_m_rall", 32'(c_m_r_all), 32'h00FF);
    chk("init_m_row", 32'(c_m_row), 32'h0100);
    chk("init_m_col", 32'(c_m_col), 32'h0000);
    chk("init_l_rall", 32'(c_l_r_all), 32'h03);
    chk("init_l_row", 32'(c_l_row), 32'h04);
    chk("init_l_col", 32'(c_l_col), 32'h03);
    chk("init_rdy", 32'(tif.tune_rdy), 32'd1);

    // L 12 -> 20 at one per clock, done on the 11th edge after accept
    request(5'd20, 9'd128, 9'd128);
    chk("acc_rdy", 32'(tif.tune_rdy), 32'd0);
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      if (i <= 8) chk("slew_l_code", 32'(code_l), 32'(12 + i));
      chk("slew_l_rdy", 32'(tif.tune_rdy), (i == 11) ? 32'd1 : 32'd0);
      chk("slew_l_done", 32'(done), (i == 11) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("l20_code", 32'(code_l), 32'd20);

    // M 128 -> 37: ceil(91/4)=23 steps, latency 26
    request(5'd20, 9'd37, 9'd128);
    wait_done(100, n);
    chk("m37_latency", 32'(n), 32'd26);
    chk("m37_code", 32'(code_m), 32'd37);
    chk("m37_rall", 32'(c_m_r_all), 32'h0003);
    chk("m37_row", 32'(c_m_row), 32'h0004);
    chk("m37_col", 32'(c_m_col), 32'h001F);

    // Clamp: L 31->25 (5 steps), S 300->256 (8 steps), latency 16
    request(5'd31, 9'd37, 9'd300);
    wait_done(100, n);
    chk("clamp_latency", 32'(n), 32'd16);
    chk("clamp_code_l", 32'(code_l), 32'd25);
    chk("clamp_code_s", 32'(code_s), 32'd256);
    chk("clamp_l_rall", 32'(c_l_r_all), 32'h1F);
    chk("clamp_l_row", 32'(c_l_row), 32'h00);
    chk("clamp_l_col", 32'(c_l_col), 32'h00);
    chk("clamp_s_rall", 32'(c_s_r_all), 32'hFFFF);
    chk("clamp_s_row", 32'(c_s_row), 32'h0000);
    chk("clamp_s_col", 32'(c_s_col), 32'h0000);

    // S 256 -> 0 in steps of 16, no wrap below zero
    request(5'd25, 9'd37, 9'd0);
    wait_done(100, n);
    chk("s0_latency", 32'(n), 32'd19);
    chk("s0_code", 32'(code_s), 32'd0);
    chk("s0_rall", 32'(c_s_r_all), 32'h0000);
    chk("s0_row", 32'(c_s_row), 32'h0001);

    // M 37 -> 0: 10 steps, last one clipped to 1
    request(5'd25, 9'd0, 9'd0);
    wait_done(100, n);
    chk("m0_latency", 32'(n), 32'd13);
    chk("m0_code", 32'(code_m), 32'd0);
    chk("m0_rall", 32'(c_m_r_all), 32'h0000);
    chk("m0_row", 32'(c_m_row), 32'h0001);
    chk("m0_col", 32'(c_m_col), 32'h0000);

    // Request equal to present codes still takes 3 cycles
    request(5'd25, 9'd0, 9'd0);
    wait_done(20, n);
    chk("eq_latency", 32'(n), 32'd3);
    chk("eq_done", 32'(done), 32'd1);

    // Abort mid SLEW_M: L 25->0 takes 26 edges, then 4 M steps reach 16
    request(5'd0, 9'd200, 9'd100);
    repeat (30) @(posedge clk);
    #1;
    chk("busy_code_l", 32'(code_l), 32'd0);
    chk("busy_code_m", 32'(code_m), 32'd16);
    chk("busy_rdy", 32'(tif.tune_rdy), 32'd0);
    @(negedge clk);
    tif.tune_l = 5'd5; tif.tune_m = 9'd5; tif.tune_s = 9'd5; tif.tune_vld = 1'b1;
    @(posedge clk); #1;
    tif.tune_vld = 1'b0;
    chk("busy_ignore_l", 32'(code_l), 32'd0);
    chk("busy_ignore_m", 32'(code_m), 32'd20);
    #3 rst = 1'b1;
    #1;
    chk("abort_code_l", 32'(code_l), 32'd12);
    chk("abort_code_m", 32'(code_m), 32'd128);
    chk("abort_code_s", 32'(code_s), 32'd128);
    chk("abort_m_rall", 32'(c_m_r_all), 32'h00FF);
    chk("abort_rdy", 32'(tif.tune_rdy), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("post_abort_done", 32'(done), 32'd0);
    end
    chk("post_abort_l", 32'(code_l), 32'd12);
    chk("post_abort_m", 32'(code_m), 32'd128);
    chk("post_abort_rdy", 32'(tif.tune_rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
